// File: rtl/aes_add_round_key_stage.sv
// rtl/aes_add_round_key_stage.sv - AES AddRoundKey stage: fetches the round key from the expander and XORs it into the state
module aes_add_round_key_stage #(
  parameter int NUM_ROUNDS    = 10,
  parameter int KEY_SEL_WIDTH = 4,
  parameter int KEY_TIMEOUT   = 64
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           in_vld,
  output logic                           in_rdy,
  input  logic                           in_first,
  input  logic [3:0][3:0][7:0]           state_in,
  output logic [KEY_SEL_WIDTH-1:0]       key_sel,
  input  logic                           key_rdy,
  input  logic [3:0][3:0][7:0]           round_key,
  output logic                           out_vld,
  input  logic                           out_rdy,
  output logic [3:0][3:0][7:0]           state_out,
  output logic [KEY_SEL_WIDTH-1:0]       out_round,
  output logic                           out_last,
  output logic                           key_err
);

  localparam int TW = $clog2(KEY_TIMEOUT + 1);
  localparam logic [KEY_SEL_WIDTH-1:0] LAST_ROUND = KEY_SEL_WIDTH'(NUM_ROUNDS);
  localparam logic [TW-1:0]            TMO_LAST   = TW'(KEY_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ_KEY,
    WAIT_KEY,
    OUT
  } state_t;

  state_t                      state;
  logic [3:0][3:0][7:0]        blk;
  logic [KEY_SEL_WIDTH-1:0]    idx;
  logic [KEY_SEL_WIDTH-1:0]    rcnt;
  logic [TW-1:0]               tcnt;

  // in_rdy is a flop so it stays low while reset is held and rises on the first edge after release
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      in_rdy    <= 1'b0;
      blk       <= '0;
      idx       <= '0;
      rcnt      <= '0;
      tcnt      <= '0;
      key_sel   <= '0;
      out_vld   <= 1'b0;
      state_out <= '0;
      out_round <= '0;
      out_last  <= 1'b0;
      key_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_vld && in_rdy) begin
            blk    <= state_in;
            idx    <= in_first ? '0 : rcnt;
            in_rdy <= 1'b0;
            state  <= REQ_KEY;
          end else begin
            in_rdy <= 1'b1;
          end
        end
        REQ_KEY: begin
          key_sel <= idx;
          tcnt    <= '0;
          state   <= WAIT_KEY;
        end
        WAIT_KEY: begin
          if (key_rdy) begin
            state_out <= blk ^ round_key;
            out_round <= idx;
            out_last  <= (idx == LAST_ROUND);
            out_vld   <= 1'b1;
            state     <= OUT;
          end else if (tcnt == TMO_LAST) begin
            // error is reported but the block keeps waiting for a late key
            key_err <= 1'b1;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        OUT: begin
          if (out_rdy) begin
            out_vld <= 1'b0;
            rcnt    <= (idx == LAST_ROUND) ? '0 : idx + KEY_SEL_WIDTH'(1);
            in_rdy  <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
